gf_mul_seq: RTL and testbench

//   Iterative GF(2^8) multiplier controller for the AES datapath (poly x^8+x^4+x^3+x+1).

---
 rtl/gf_mul_seq_pkg.sv | 14 +
 rtl/gf_mul_seq_xtime.sv | 11 +
 rtl/gf_mul_seq.sv | 86 ++++++++
 tb/tb_gf_mul_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/gf_mul_seq_pkg.sv
// gf_mul_seq_pkg: shared AES byte type, reduction constant and controller state encoding.
package gf_mul_seq_pkg;

    typedef logic [7:0] t_byte;

    localparam t_byte AES_POLY_RED = 8'h1B;

    typedef enum logic [1:0] {IDLE, RUN, DONE} t_state;

    function automatic t_byte xtime(input t_byte a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_RED : 8'h00);
    endfunction

endpackage

// File: rtl/gf_mul_seq_xtime.sv
// gf_mul_seq_xtime: multiply a byte by x in GF(2^8), folding the AES polynomial on overflow.
module gf_mul_seq_xtime
    import gf_mul_seq_pkg::*;
(
    input  t_byte a_i,
    output t_byte y_o
);

    assign y_o = xtime(a_i);

endmodule

// File: rtl/gf_mul_seq.sv
// gf_mul_seq: iterative GF(2^8) shift-and-add multiplier with valid/ready operand and result handshakes.
module gf_mul_seq
    import gf_mul_seq_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_lhs,
    input  logic [7:0] in_rhs,
    input  logic       abort,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy
);

    t_state     state_q, state_d;
    t_byte      a_q, a_d, b_q, b_d, acc_q, acc_d, a_x;
    logic [2:0] cnt_q, cnt_d;

    gf_mul_seq_xtime u_xtime (
        .a_i(a_q),
        .y_o(a_x)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = IDLE;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    a_d     = in_lhs;
                    b_d     = in_rhs;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (EARLY_EXIT && in_rhs == 8'h00) ? DONE : RUN;
                end
                RUN: begin
                    acc_d = acc_q ^ (b_q[0] ? a_q : 8'h00);
                    a_d   = a_x;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + 3'd1;
                    // b_q[7:1] is the multiplier left after this step
                    if ((EARLY_EXIT && b_q[7:1] == 7'd0) || cnt_q == 3'd7)
                        state_d = DONE;
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            in_ready  <= state_d == IDLE;
            out_valid <= state_d == DONE;
            out_data  <= state_d == DONE ? acc_d : 8'h00;
            busy      <= state_d != IDLE;
        end
    end

endmodule

// File: tb/tb_gf_mul_seq.sv
// tb_gf_mul_seq: directed and random checks of gf_mul_seq; index 0 runs EARLY_EXIT=0, index 1 EARLY_EXIT=1.
module tb_gf_mul_seq;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      in_valid, in_ready, abort, out_valid, out_ready, busy;
    logic [1:0][7:0] in_lhs, in_rhs, out_data;
    int              n_checks = 0;
    int              n_fail = 0;

    always #5 clk = ~clk;

    gf_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_lhs(in_lhs[0]), .in_rhs(in_rhs[0]), .abort(abort[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
    );

    gf_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_lhs(in_lhs[1]), .in_rhs(in_rhs[1]), .abort(abort[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] l, input logic [7:0] r);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (r[i]) p ^= l;
            l = {l[6:0], 1'b0} ^ (l[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic int exp_lat(input int ee, input logic [7:0] r);
        int m = 0;
        if (ee == 0) return 9;
        if (r == 8'h00) return 1;
        for (int i = 0; i < 8; i++) if (r[i]) m = i;
        return m + 2;
    endfunction

    task automatic run_op(input int s, input logic [7:0] l, input logic [7:0] r,
                          input logic [7:0] e, input int lat_e, input int hold);
        int lat;
        check("in_ready_idle", in_ready[s], 1);
        in_valid[s] = 1'b1;
        in_lhs[s]   = l;
        in_rhs[s]   = r;
        @(negedge clk);
        in_valid[s] = 1'b0;
        lat = 1;
        while (!out_valid[s] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid", out_valid[s], 1);
        check("latency", lat, lat_e);
        check("product", out_data[s], e);
        check("busy_done", busy[s], 1);
        check("in_ready_done", in_ready[s], 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid[s], 1);
            check("hold_data", out_data[s], e);
            check("hold_in_ready", in_ready[s], 0);
        end
        out_ready[s] = 1'b1;
        @(negedge clk);
        out_ready[s] = 1'b0;
        check("in_ready_after", in_ready[s], 1);
        check("out_valid_after", out_valid[s], 0);
        check("out_data_after", out_data[s], 0);
    endtask

    initial begin
        int seen;
        logic [7:0] l, r;
        rst = 1'b1;
        in_valid = '0; abort = '0; out_ready = '0; in_lhs = '0; in_rhs = '0;
        #3;
        for (int s = 0; s < 2; s++) begin
            check("rst_in_ready", in_ready[s], 1);
            check("rst_out_valid", out_valid[s], 0);
            check("rst_out_data", out_data[s], 0);
            check("rst_busy", busy[s], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(1, 8'h57, 8'h83, 8'hC1, 9, 0);
        run_op(1, 8'h57, 8'h13, 8'hFE, 6, 0);
        run_op(0, 8'h57, 8'h13, 8'hFE, 9, 0);
        run_op(1, 8'h80, 8'h02, 8'h1B, 3, 0);
        run_op(1, 8'hA5, 8'h00, 8'h00, 1, 0);
        run_op(0, 8'hA5, 8'h00, 8'h00, 9, 0);
        run_op(1, 8'h57, 8'h83, 8'hC1, 9, 5);

        // abort in the third RUN cycle, colliding with a new operand offer
        in_valid[1] = 1'b1; in_lhs[1] = 8'h57; in_rhs[1] = 8'h83;
        @(negedge clk);
        in_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_before", busy[1], 1);
        abort[1] = 1'b1; in_valid[1] = 1'b1; in_lhs[1] = 8'h02; in_rhs[1] = 8'h57;
        @(negedge clk);
        abort[1] = 1'b0; in_valid[1] = 1'b0;
        check("abort_in_ready", in_ready[1], 1);
        check("abort_busy", busy[1], 0);
        check("abort_out_valid", out_valid[1], 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid[1] || busy[1]) seen = 1;
        end
        check("abort_no_pulse", seen, 0);
        run_op(1, 8'h02, 8'h57, 8'hAE, 8, 0);

        // asynchronous reset between clock edges while both units are running
        in_valid = 2'b11; in_lhs = {8'h57, 8'h57}; in_rhs = {8'h83, 8'h83};
        @(negedge clk);
        in_valid = 2'b00;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            check("arst_in_ready", in_ready[s], 1);
            check("arst_out_valid", out_valid[s], 0);
            check("arst_out_data", out_data[s], 0);
            check("arst_busy", busy[s], 0);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        run_op(1, 8'h57, 8'h83, 8'hC1, 9, 0);
        run_op(0, 8'h57, 8'h13, 8'hFE, 9, 0);

        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 1000; k++) begin
                l = 8'($urandom_range(0, 255));
                r = 8'($urandom_range(0, 255));
                run_op(s, l, r, gmul(l, r), exp_lat(s, r), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
